pipe_addsub: RTL and testbench

Pipelined, parametrised add/subtract unit. It replaces single-cycle ripple adders on wide datapaths where the full carry chain does not close timing. The carry chain is split into `N_STAGES` equal segments, with one segment per pipeline stage, and the carry is registered between segments. Operands enter and results leave through valid/ready handshakes. Sustained throughput is one operation per cycle.

---
 rtl/pipe_addsub_if.sv | 31 +++
 rtl/pipe_addsub.sv | 106 ++++++++++
 tb/tb_pipe_addsub.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
// pipe_addsub_if : operand/result valid-ready bundle for pipe_addsub.
// Rev 1.0
// ============================================================================
interface pipe_addsub_if #(
   parameter int N_BITS = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [N_BITS-1:0] a;
   logic [N_BITS-1:0] b;
   logic              cin;
   logic              op_sub;
   logic              out_valid;
   logic              out_ready;
   logic [N_BITS-1:0] sum;
   logic              cout;
   logic              ovf;

   modport master (
      output in_valid, a, b, cin, op_sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, op_sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// pipe_addsub : add/subtract with the carry chain cut into N_STAGES registered
// segments. Define PIPE_ADDSUB_SAT_EN to saturate sum on signed overflow.
// Rev 1.0
// ============================================================================
module pipe_addsub #(
   parameter int N_BITS   = 16,
   parameter int N_STAGES = 4
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   pipe_addsub_if.slave bus
);
   localparam int c_SEG_W = N_BITS / N_STAGES;
   localparam int c_LAST  = N_STAGES - 1;

   if ((N_STAGES < 1) || (N_STAGES > N_BITS) || ((N_BITS % N_STAGES) != 0)) begin : g_bad_cfg
      $error("pipe_addsub: N_BITS must be a multiple of N_STAGES, 1 <= N_STAGES <= N_BITS");
   end

   logic [N_STAGES-1:0] r_vld;
   logic [N_BITS-1:0]   r_a [N_STAGES];
   logic [N_BITS-1:0]   r_b [N_STAGES];
   logic [N_BITS-1:0]   r_s [N_STAGES];
   logic [N_STAGES-1:0] r_c;
   logic                r_ovf;

   logic [N_BITS-1:0]   w_ai   [N_STAGES];
   logic [N_BITS-1:0]   w_bi   [N_STAGES];
   logic [N_BITS-1:0]   w_si   [N_STAGES];
   logic [N_BITS-1:0]   w_s_nx [N_STAGES];
   logic [c_SEG_W:0]    w_t    [N_STAGES];
   logic [N_STAGES-1:0] w_ci;
   logic [N_STAGES-1:0] w_c_nx;
   logic [N_STAGES-1:0] w_vld_nx;
   logic                w_ovf_nx;
   logic                w_adv;

   // The whole pipe moves as one; a full output stage blocks everything behind it.
   assign w_adv         = !r_vld[c_LAST] || bus.out_ready;
   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_vld[c_LAST];
   assign bus.sum       = r_s[c_LAST];
   assign bus.cout      = r_c[c_LAST];
   assign bus.ovf       = r_ovf;

   always_comb begin
      w_ai[0]     = bus.a;
      w_bi[0]     = bus.op_sub ? ~bus.b : bus.b;
      w_ci[0]     = bus.cin ^ bus.op_sub;
      w_si[0]     = '0;
      w_vld_nx[0] = bus.in_valid;
      for (int k = 1; k < N_STAGES; k++) begin
         w_ai[k]     = r_a[k-1];
         w_bi[k]     = r_b[k-1];
         w_ci[k]     = r_c[k-1];
         w_si[k]     = r_s[k-1];
         w_vld_nx[k] = r_vld[k-1];
      end
      for (int k = 0; k < N_STAGES; k++) begin
         w_t[k] = {1'b0, w_ai[k][k*c_SEG_W +: c_SEG_W]}
                + {1'b0, w_bi[k][k*c_SEG_W +: c_SEG_W]}
                + {{c_SEG_W{1'b0}}, w_ci[k]};
         w_s_nx[k]                       = w_si[k];
         w_s_nx[k][k*c_SEG_W +: c_SEG_W] = w_t[k][c_SEG_W-1:0];
         w_c_nx[k]                       = w_t[k][c_SEG_W];
      end
      w_ovf_nx = (w_ai[c_LAST][N_BITS-1] == w_bi[c_LAST][N_BITS-1])
              && (w_s_nx[c_LAST][N_BITS-1] != w_ai[c_LAST][N_BITS-1]);
`ifdef PIPE_ADDSUB_SAT_EN
      if (w_ovf_nx) begin
         w_s_nx[c_LAST] = w_ai[c_LAST][N_BITS-1] ? {1'b1, {(N_BITS-1){1'b0}}}
                                                 : {1'b0, {(N_BITS-1){1'b1}}};
      end
`endif
   end

   // Data registers load only with a valid beat so idle outputs stay quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < N_STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_adv) begin
         r_vld <= w_vld_nx;
         for (int k = 0; k < N_STAGES; k++) begin
            if (w_vld_nx[k]) begin
               r_a[k] <= w_ai[k];
               r_b[k] <= w_bi[k];
               r_s[k] <= w_s_nx[k];
               r_c[k] <= w_c_nx[k];
            end
         end
         if (w_vld_nx[c_LAST]) begin
            r_ovf <= w_ovf_nx;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// tb_pipe_addsub : directed vector table plus back-pressure and reset sequences.
module tb_pipe_addsub;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   pipe_addsub_if #(.N_BITS(16)) bus ();

   pipe_addsub #(.N_BITS(16), .N_STAGES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        op_sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference from the arithmetic definition: {cout, ovf, sum}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
      logic [15:0] be;
      logic [16:0] f;
      logic        o;
      logic [15:0] s;
      be = sub ? ~b : b;
      f  = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? ~cin : cin)};
      o  = (a[15] == be[15]) && (f[15] != a[15]);
      s  = f[15:0];
`ifdef PIPE_ADDSUB_SAT_EN
      if (o) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {f[16], o, s};
   endfunction

   logic [15:0] bp_a [8];
   logic [15:0] bp_b [8];
   logic        bp_c [8];
   logic        bp_s [8];
   logic [17:0] exp_q [$];

   initial begin
      logic [17:0] e;
      int sent, recvd, cyc, seen;
      bit lat_ok, stall, acc, ret;
      n_checks = 0;
      n_errors = 0;

`ifdef PIPE_ADDSUB_SAT_EN
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
      vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

      // Reset held for three cycles
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.op_sub = 1'b0; bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed vectors, one at a time, with latency check
      for (int i = 0; i < 9; i++) begin
         bus.a = vecs[i].a; bus.b = vecs[i].b; bus.cin = vecs[i].cin;
         bus.op_sub = vecs[i].op_sub; bus.in_valid = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         lat_ok = 1'b1;
         for (int c = 0; c < 3; c++) begin
            if (bus.out_valid) lat_ok = 1'b0;
            tick();
         end
         if (!bus.out_valid) lat_ok = 1'b0;
         check($sformatf("vec%0d_latency", i), 32'(lat_ok), 32'd1);
         check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].sum));
         check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
         check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
         tick();
         check($sformatf("vec%0d_retired", i), 32'(bus.out_valid), 32'd0);
      end

      // Back-pressure: 8 back-to-back beats, out_ready low in cycles 5..7
      for (int i = 0; i < 8; i++) begin
         bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom);
         bp_c[i] = 1'($urandom); bp_s[i] = 1'($urandom);
      end
      sent = 0; recvd = 0; cyc = 0;
      while (recvd < 8 && cyc < 60) begin
         stall = (cyc >= 5 && cyc <= 7);
         bus.out_ready = !stall;
         bus.in_valid  = (sent < 8);
         if (sent < 8) begin
            bus.a = bp_a[sent]; bus.b = bp_b[sent];
            bus.cin = bp_c[sent]; bus.op_sub = bp_s[sent];
         end
         #1;
         check($sformatf("bp_in_ready_c%0d", cyc), 32'(bus.in_ready), 32'(!stall));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check($sformatf("bp_spurious_c%0d", cyc), 32'(bus.out_valid), 32'd0);
            end else begin
               check($sformatf("bp_result_c%0d", cyc),
                     32'({bus.cout, bus.ovf, bus.sum}), 32'(exp_q[0]));
            end
         end
         acc = bus.in_valid && bus.in_ready;
         ret = bus.out_valid && bus.out_ready;
         tick();
         if (ret && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            recvd++;
         end
         if (acc) begin
            exp_q.push_back(model(bp_a[sent], bp_b[sent], bp_c[sent], bp_s[sent]));
            sent++;
         end
         cyc++;
      end
      check("bp_all_retired", 32'(recvd), 32'd8);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // Reset with the output stage full and three beats behind it
      for (int i = 0; i < 4; i++) begin
         bus.a = 16'(i + 1); bus.b = 16'h0100; bus.cin = 1'b0; bus.op_sub = 1'b0;
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("mid_pre_out_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_async_sum", 32'(bus.sum), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("mid_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      check("mid_no_ghost_results", 32'(seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
